uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter: control FSM, baud divider, shift register and parity in one block.
//  Accepts one data word per valid/ready handshake and serialises it LSB first.
//  Frame format: start bit, data bits, optional parity bit, then 1 or 2 stop bits.
//  Sits between a byte-producing host (FIFO or CPU register) and the serial TX pin.
// PARAMETERS
//  DATA_BITS     8   data bits per frame; legal range 5..9
//  CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 2
//  PARITY_MODE   0   0 = no parity, 1 = even parity, 2 = odd parity
//  STOP_BITS     1   number of stop bits; 1 or 2
// PORTS
//  clk       in   1          single clock; all logic on the rising edge
//  rst_n     in   1          synchronous, active-low reset
//  tx_data   in   DATA_BITS  word to send; sampled only on a handshake
//  tx_valid  in   1          host has a word on tx_data
//  tx_ready  out  1          block can accept a word; equals (state==IDLE)
//  tx        out  1          serial line; registered; idles high
//  busy      out  1          high in every state except IDLE
//  done      out  1          one-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  Clocking and reset:
//   - One clock. Reset is synchronous and active-low.
//   - rst_n low at a rising edge forces: state=IDLE, tx=1, done=0, all counters and the shift register cleared.
//   - busy=0 and tx_ready=1 follow from state=IDLE.
//  FSM states and transitions:
//   - IDLE -> START on the edge where tx_valid && tx_ready.
//   - START -> DATA.
//   - DATA -> PARITY if PARITY_MODE != 0, otherwise DATA -> STOP.
//   - PARITY -> STOP.
//   - STOP -> IDLE.
//  Handshake:
//   - On acceptance, capture tx_data into the shift register.
//   - On acceptance, compute parity from the captured word: even = ^data, odd = ~^data.
//   - On acceptance, set tx<=0 at the same edge.
//   - When not in IDLE: ignore tx_valid and any change on tx_data.
//  Bit timing:
//   - baud_cnt counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
//   - Each bit occupies exactly CLKS_PER_BIT cycles on tx.
//   - A state or bit advances only when baud_cnt == CLKS_PER_BIT-1. At that edge, baud_cnt wraps to 0.
//   - DATA: shift LSB first. bit_cnt counts 0..DATA_BITS-1; leave DATA when bit_cnt == DATA_BITS-1 and baud wraps.
//   - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; a stop counter is used when STOP_BITS == 2.
//  Frame length and completion:
//   - N = 1 + DATA_BITS + (PARITY_MODE != 0) + STOP_BITS.
//   - Accept edge to done edge is exactly N*CLKS_PER_BIT cycles.
//   - done is registered and high for the single cycle after the STOP -> IDLE edge.
//   - In that same cycle tx_ready=1, so a new word can be accepted at the next edge.
//   - Back-to-back: tx_valid held high gives exactly one idle-high clk between frames.
//  Widths:
//   - baud_cnt is $clog2(CLKS_PER_BIT) bits wide; bit_cnt is $clog2(DATA_BITS) bits wide.
//   - No counter may overflow for any legal parameter value.
//  Reset mid-frame: abort at that edge with no done pulse; tx returns high and the next frame is clean.
//  Illegal parameters cause an elaboration-time error ($error in a generate check).
// TESTING
//  1. Defaults, send 0xA5 -> tx low 16 cycles, then 1,0,1,0,0,1,0,1 (16 cycles each), high 16; done 160 cycles after accept.
//  2. PARITY_MODE=1, send 0x07 -> parity bit 1, frame 176 cycles. PARITY_MODE=2, send 0x07 -> parity bit 0.
//  3. STOP_BITS=2, DATA_BITS=7, send 0x7F -> stop high for 32 cycles; done 160 cycles after accept.
//  4. tx_valid held with 0x55 then 0xAA -> exactly 1 idle-high cycle between frames; done pulses twice, 161 cycles apart.
//  5. rst_n low for 1 cycle during data bit 3 -> next cycle tx=1, busy=0, no done; following 0x3C frame is bit-exact.
//  6. tx_valid pulsed with 0xFF while busy sending 0x00 -> 0xFF is ignored; line carries only 0x00; tx_ready stays 0 until done.

Source files
------------

// File: rtl/uart_tx_param.sv
// uart_tx_param: parameterised UART transmitter.
// Sends start bit, DATA_BITS data bits LSB first, an optional parity bit, and
// STOP_BITS stop bits. Each bit is CLKS_PER_BIT clocks long. Words are taken in
// through a valid/ready handshake that is only open in IDLE. The tx line and
// the done pulse are both registered.
module uart_tx_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  // Guard the widths so that illegal values still reach the checks below
  // rather than failing on a zero-width vector first.
  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   baud_wrap;

  assign baud_wrap = (baud_q == BAUD_MAX);
  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign tx        = tx_q;
  assign done      = done_q;

  // Next state, counters, shift register and line level. The value loaded
  // into tx_d is the level of the bit that starts at the coming edge.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    // Baud counter runs in every state but IDLE and wraps on the bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = baud_wrap ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        tx_d   = 1'b1;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          par_d   = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (baud_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      S_DATA: begin
        if (baud_wrap) begin
          if (bit_q == BIT_MAX) begin
            stop_d = 1'b0;
            if (PARITY_MODE != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_wrap) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_wrap) begin
          // stop_q marks the second stop bit; with one stop bit it stays 0.
          if (STOP_BITS == 1 || stop_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover default framing,
// even and odd parity, and 2 stop bits with 7 data bits.
module tb_uart_tx_param;

  localparam int C = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid_r;
  logic [7:0] dat8 [3];
  logic [6:0] dat7;
  logic [3:0] tx_w, busy_w, rdy_w, done_w;

  int n_cmp;
  int n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: defaults, 1: even parity, 2: odd parity, 3: DATA_BITS=7 STOP_BITS=2
  uart_tx_param u_d0 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat8[0]), .tx_valid(valid_r[0]),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0])
  );
  uart_tx_param #(.PARITY_MODE(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat8[1]), .tx_valid(valid_r[1]),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1])
  );
  uart_tx_param #(.PARITY_MODE(2)) u_p2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat8[2]), .tx_valid(valid_r[2]),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2])
  );
  uart_tx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_s2 (
    .clk(clk), .rst_n(rst_n), .tx_data(dat7), .tx_valid(valid_r[3]),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .done(done_w[3])
  );

  task automatic set_data(input int sel, input logic [7:0] d);
    if (sel == 3) dat7 = d[6:0];
    else dat8[sel] = d;
  endtask

  // Sends one word on instance sel and checks the line cycle by cycle against
  // frame (bit i = level of serial bit i, start bit first). Optionally pulses
  // tx_valid with gdata at cycle glitch_k while the frame is in flight.
  task automatic run_frame(input int sel, input logic [7:0] din,
                           input logic [15:0] frame, input int nbits,
                           input int glitch_k, input logic [7:0] gdata,
                           input string name);
    bit win_bad, ctl_bad, done_bad;
    int total;
    total = nbits * C;
    ctl_bad  = 0;
    done_bad = 0;
    win_bad  = 0;
    @(negedge clk);
    n_cmp++;
    if (rdy_w[sel] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_before got %b exp 1", name, rdy_w[sel]);
    end
    valid_r[sel] = 1'b1;
    set_data(sel, din);
    @(posedge clk);
    @(negedge clk);
    valid_r[sel] = 1'b0;
    set_data(sel, ~din);
    for (int k = 0; k <= total; k++) begin
      if (k > 0) @(negedge clk);
      if (k < total) begin
        if (k % C == 0) win_bad = 0;
        if (tx_w[sel] !== frame[k / C]) win_bad = 1;
        if (busy_w[sel] !== 1'b1 || rdy_w[sel] !== 1'b0) ctl_bad = 1;
        if (done_w[sel] !== 1'b0) done_bad = 1;
        if (k % C == C - 1) begin
          n_cmp++;
          if (win_bad) begin
            n_bad++;
            $display("FAIL %s bit%0d wrong level/length exp %b", name, k / C, frame[k / C]);
          end
        end
      end else begin
        n_cmp++;
        if (done_w[sel] !== 1'b1) begin
          n_bad++;
          $display("FAIL %s done_at_end got %b exp 1", name, done_w[sel]);
        end
        n_cmp++;
        if (tx_w[sel] !== 1'b1 || rdy_w[sel] !== 1'b1 || busy_w[sel] !== 1'b0) begin
          n_bad++;
          $display("FAIL %s idle_at_end got tx=%b rdy=%b busy=%b exp 1 1 0",
                   name, tx_w[sel], rdy_w[sel], busy_w[sel]);
        end
      end
      if (glitch_k >= 0 && k == glitch_k) begin
        valid_r[sel] = 1'b1;
        set_data(sel, gdata);
      end
      if (glitch_k >= 0 && k == glitch_k + 1) valid_r[sel] = 1'b0;
    end
    n_cmp++;
    if (ctl_bad) begin
      n_bad++;
      $display("FAIL %s busy_ready_in_frame got glitch exp busy=1 rdy=0", name);
    end
    n_cmp++;
    if (done_bad) begin
      n_bad++;
      $display("FAIL %s early_done got 1 exp 0", name);
    end
    @(negedge clk);
    n_cmp++;
    if (done_w[sel] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width got %b exp 0", name, done_w[sel]);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    valid_r = '0;
    for (int i = 0; i < 3; i++) dat8[i] = '0;
    dat7 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (tx_w[i] !== 1'b1 || busy_w[i] !== 1'b0 || rdy_w[i] !== 1'b1 || done_w[i] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d got tx=%b busy=%b rdy=%b done=%b exp 1 0 1 0",
                 i, tx_w[i], busy_w[i], rdy_w[i], done_w[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_frame(0, 8'hA5, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00, "basic_A5");
  endtask

  task automatic test_parity();
    run_frame(1, 8'h07, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, -1, 8'h00, "even_07");
    run_frame(2, 8'h07, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, -1, 8'h00, "odd_07");
  endtask

  task automatic test_stop2();
    run_frame(3, 8'h7F, {6'b0, 2'b11, 7'h7F, 1'b0}, 10, -1, 8'h00, "stop2_7F");
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1, f2;
    bit tx_bad;
    int d1, d2, nd;
    logic exp;
    f1 = {6'b0, 1'b1, 8'h55, 1'b0};
    f2 = {6'b0, 1'b1, 8'hAA, 1'b0};
    tx_bad = 0;
    d1 = -1;
    d2 = -1;
    nd = 0;
    @(negedge clk);
    valid_r[0] = 1'b1;
    dat8[0] = 8'h55;
    @(posedge clk);
    @(negedge clk);
    dat8[0] = 8'hAA;
    for (int k = 0; k <= 330; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 160)      exp = f1[k / C];
      else if (k < 161) exp = 1'b1;
      else if (k < 321) exp = f2[(k - 161) / C];
      else              exp = 1'b1;
      if (tx_w[0] !== exp) tx_bad = 1;
      if (done_w[0] === 1'b1) begin
        nd++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (k == 161) valid_r[0] = 1'b0;
    end
    n_cmp++;
    if (tx_bad) begin
      n_bad++;
      $display("FAIL b2b_line got wrong waveform exp 55,1 idle,AA");
    end
    n_cmp++;
    if (d1 != 160) begin
      n_bad++;
      $display("FAIL b2b_first_done got %0d exp 160", d1);
    end
    n_cmp++;
    if (d2 - d1 != 161 || nd != 2) begin
      n_bad++;
      $display("FAIL b2b_done_spacing got %0d (count %0d) exp 161 (count 2)", d2 - d1, nd);
    end
  endtask

  task automatic test_reset_midframe();
    bit bad;
    bad = 0;
    @(negedge clk);
    valid_r[0] = 1'b1;
    dat8[0] = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    valid_r[0] = 1'b0;
    repeat (70) @(negedge clk);
    n_cmp++;
    if (tx_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_bit3_level got %b exp 0", tx_w[0]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_abort got tx=%b busy=%b rdy=%b done=%b exp 1 0 1 0",
               tx_w[0], busy_w[0], rdy_w[0], done_w[0]);
    end
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) bad = 1;
    end
    n_cmp++;
    if (bad) begin
      n_bad++;
      $display("FAIL midreset_quiet got activity exp idle no done");
    end
    run_frame(0, 8'h3C, {6'b0, 1'b1, 8'h3C, 1'b0}, 10, -1, 8'h00, "after_reset_3C");
  endtask

  task automatic test_ignore_busy();
    run_frame(0, 8'h00, {6'b0, 1'b1, 8'h00, 1'b0}, 10, 40, 8'hFF, "ignore_FF");
    n_cmp++;
    if (busy_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_no_second_frame got busy=%b tx=%b exp 0 1", busy_w[0], tx_w[0]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_back_to_back();
    test_reset_midframe();
    test_ignore_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
